// File: rtl/swipt_freq_tracker.sv
// Perturb-and-observe frequency tracker for the SWIPT link: settle, average ADC samples,
// step freq toward higher received amplitude, and flag lock while dithering at the peak.
module swipt_freq_tracker #(
  parameter logic [19:0] FREQ_INIT  = 20'h09C40,
  parameter logic [19:0] FREQ_MIN   = 20'h08000,
  parameter logic [19:0] FREQ_MAX   = 20'h0C000,
  parameter logic [19:0] STEP       = 20'h00040,
  parameter logic [11:0] DUTY       = 12'h0FA,
  parameter int          SETTLE_CYC = 1000,
  parameter int          AVG_LOG2   = 3,
  parameter int          REV_LOCK   = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic        enable,
  input  logic [11:0] adc_in,
  input  logic        adc_valid,
  output logic [19:0] freq,
  output logic [11:0] l,
  output logic        freq_update,
  output logic        locked,
  output logic [2:0]  state
);

  localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam int REV_W  = $clog2(REV_LOCK + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [REV_W-1:0]  REV_MAX     = REV_W'(REV_LOCK);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ACCUM  = 3'd2,
    DECIDE = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [19:0]        freq_q, freq_d;
  logic               dir_up_q, dir_up_d;
  logic [11:0]        prev_avg_q, prev_avg_d;
  logic               first_q, first_d;
  logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic               locked_q, locked_d;
  logic               freq_update_q, freq_update_d;

  logic               run;
  logic [11:0]        avg;
  logic               dec_dir;
  logic [REV_W-1:0]   dec_rev;
  logic [20:0]        up_sum;
  logic [19:0]        dec_freq;

  // Decision datapath; only committed when the FSM sits in DECIDE with run still high.
  always_comb begin
    run     = enable & swiptAlive;
    avg     = acc_q[ACC_W-1:AVG_LOG2];
    dec_dir = dir_up_q;
    dec_rev = rev_cnt_q;
    if (!first_q) begin
      if (avg >= prev_avg_q) begin
        dec_rev = '0;
      end else begin
        dec_dir = ~dir_up_q;
        if (rev_cnt_q < REV_MAX) dec_rev = rev_cnt_q + 1'b1;
      end
    end
    // 21-bit headroom so a step past either limit saturates instead of wrapping.
    up_sum   = {1'b0, freq_q} + {1'b0, STEP};
    dec_freq = freq_q - STEP;
    if (dec_dir) begin
      if (up_sum > {1'b0, FREQ_MAX}) begin
        dec_freq = FREQ_MAX;
        dec_dir  = 1'b0;
      end else begin
        dec_freq = up_sum[19:0];
      end
    end else if ({1'b0, freq_q} < ({1'b0, FREQ_MIN} + {1'b0, STEP})) begin
      dec_freq = FREQ_MIN;
      dec_dir  = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    acc_d         = acc_q;
    scnt_d        = scnt_q;
    freq_d        = freq_q;
    dir_up_d      = dir_up_q;
    prev_avg_d    = prev_avg_q;
    first_d       = first_q;
    rev_cnt_d     = rev_cnt_q;
    locked_d      = locked_q;
    freq_update_d = 1'b0;

    if (state_q != IDLE && !run) begin
      // Losing run drops any half-finished measurement; freq and dir survive.
      state_d   = IDLE;
      acc_d     = '0;
      scnt_d    = '0;
      first_d   = 1'b1;
      rev_cnt_d = '0;
      locked_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_d      = SETTLE;
            settle_cnt_d = SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_d = ACCUM;
            acc_d   = '0;
            scnt_d  = '0;
          end else begin
            settle_cnt_d = settle_cnt_q - 1'b1;
          end
        end
        ACCUM: begin
          if (adc_valid) begin
            acc_d  = acc_q + ACC_W'(adc_in);
            scnt_d = scnt_q + 1'b1;
            if (scnt_q == LAST_SAMPLE) state_d = DECIDE;
          end
        end
        DECIDE: begin
          first_d       = 1'b0;
          prev_avg_d    = avg;
          rev_cnt_d     = dec_rev;
          dir_up_d      = dec_dir;
          freq_d        = dec_freq;
          freq_update_d = (dec_freq != freq_q);
          if (dec_rev == REV_MAX) locked_d = 1'b1;
          else if (dec_rev == '0) locked_d = 1'b0;
          state_d       = SETTLE;
          settle_cnt_d  = SETTLE_LOAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q       <= IDLE;
      settle_cnt_q  <= '0;
      acc_q         <= '0;
      scnt_q        <= '0;
      freq_q        <= FREQ_INIT;
      dir_up_q      <= 1'b1;
      prev_avg_q    <= '0;
      first_q       <= 1'b1;
      rev_cnt_q     <= '0;
      locked_q      <= 1'b0;
      freq_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      acc_q         <= acc_d;
      scnt_q        <= scnt_d;
      freq_q        <= freq_d;
      dir_up_q      <= dir_up_d;
      prev_avg_q    <= prev_avg_d;
      first_q       <= first_d;
      rev_cnt_q     <= rev_cnt_d;
      locked_q      <= locked_d;
      freq_update_q <= freq_update_d;
    end
  end

  assign freq        = freq_q;
  assign l           = DUTY;
  assign freq_update = freq_update_q;
  assign locked      = locked_q;
  assign state       = state_q;

endmodule

// File: tb/tb_swipt_freq_tracker.sv
// Bench for swipt_freq_tracker: three instances (nominal, near FREQ_MAX, near FREQ_MIN)
// checked every cycle against an epoch-level behavioural model plus directed literals.
module tb_swipt_freq_tracker;

  localparam int SETTLE = 1000;
  localparam int NS     = 8;
  localparam int STEPV  = 'h40;
  localparam int FMIN   = 'h8000;
  localparam int FMAX   = 'hC000;
  localparam logic [19:0] FINIT [3] = '{20'h09C40, 20'h0BFE0, 20'h08020};

  logic        clk  = 1'b0;
  logic        nrst = 1'b1;
  logic [2:0]  en    = 3'b000;
  logic [2:0]  alive = 3'b111;
  logic [2:0]  valid = 3'b111;
  logic [11:0] val0  = 12'd1000;
  logic [11:0] adc    [3];
  logic [19:0] freq_o [3];
  logic [11:0] l_o    [3];
  logic [2:0]  st_o   [3];
  logic [2:0]  upd_o;
  logic [2:0]  lock_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Amplitude seen by each instance: ch0 directed, ch1 rises with freq, ch2 falls with freq.
  assign adc[0] = val0;
  assign adc[1] = 12'(freq_o[1] >> 6);
  assign adc[2] = 12'hFFF - 12'(freq_o[2] >> 6);

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    swipt_freq_tracker #(.FREQ_INIT(FINIT[gi])) u_dut (
      .clk        (clk),
      .nrst       (nrst),
      .swiptAlive (alive[gi]),
      .enable     (en[gi]),
      .adc_in     (adc[gi]),
      .adc_valid  (valid[gi]),
      .freq       (freq_o[gi]),
      .l          (l_o[gi]),
      .freq_update(upd_o[gi]),
      .locked     (lock_o[gi]),
      .state      (st_o[gi])
    );
  end

  function automatic void chk(string nm, int c, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL ch%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", c, nm, act, exp, $time);
    end
  endfunction

  // Model: an epoch starts when run rises; SETTLE cycles elapse, NS samples gather, one decision.
  bit m_act [3];
  int m_et [3], m_ns [3], m_sum [3], m_f [3], m_prev [3], m_rev [3];
  bit m_up [3], m_first [3], m_lock [3], m_upd [3];

  function automatic int exp_state(int c);
    if (!m_act[c]) return 0;
    if (m_et[c] < SETTLE) return 1;
    if (m_ns[c] < NS) return 2;
    return 3;
  endfunction

  always @(posedge clk or posedge nrst) begin
    for (int c = 0; c < 3; c++) begin
      automatic bit run = en[c] & alive[c];
      automatic bit up  = m_up[c];
      automatic int rev = m_rev[c];
      automatic int avg = m_sum[c] / NS;
      automatic int f   = 0;
      if (nrst) begin
        m_act[c] <= 0; m_et[c] <= 0; m_ns[c] <= 0; m_sum[c] <= 0;
        m_f[c] <= int'(FINIT[c]); m_up[c] <= 1; m_prev[c] <= 0; m_first[c] <= 1;
        m_rev[c] <= 0; m_lock[c] <= 0; m_upd[c] <= 0;
      end else begin
        m_upd[c] <= 0;
        if (!m_act[c]) begin
          if (run) begin
            m_act[c] <= 1; m_et[c] <= 0; m_ns[c] <= 0; m_sum[c] <= 0;
          end
        end else if (!run) begin
          m_act[c] <= 0; m_first[c] <= 1; m_rev[c] <= 0; m_lock[c] <= 0;
          m_ns[c] <= 0; m_sum[c] <= 0;
        end else if (m_et[c] < SETTLE) begin
          m_et[c] <= m_et[c] + 1;
        end else if (m_ns[c] < NS) begin
          if (valid[c]) begin
            m_sum[c] <= m_sum[c] + int'(adc[c]);
            m_ns[c]  <= m_ns[c] + 1;
          end
        end else begin
          if (!m_first[c]) begin
            if (avg >= m_prev[c]) rev = 0;
            else begin
              up  = !up;
              rev = (rev < 4) ? rev + 1 : 4;
            end
          end
          f = up ? m_f[c] + STEPV : m_f[c] - STEPV;
          if (f > FMAX) begin f = FMAX; up = 0; end
          else if (f < FMIN) begin f = FMIN; up = 1; end
          m_first[c] <= 0; m_prev[c] <= avg; m_rev[c] <= rev; m_up[c] <= up;
          m_f[c] <= f; m_upd[c] <= (f != m_f[c]);
          if (rev == 4) m_lock[c] <= 1;
          else if (rev == 0) m_lock[c] <= 0;
          m_et[c] <= 0; m_ns[c] <= 0; m_sum[c] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      chk("freq",        c, freq_o[c], m_f[c]);
      chk("l",           c, l_o[c],    'h0FA);
      chk("freq_update", c, upd_o[c],  m_upd[c]);
      chk("locked",      c, lock_o[c], m_lock[c]);
      chk("state",       c, st_o[c],   exp_state(c));
    end
  end

  task automatic wait_state(input int c, input int s, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (st_o[c] == 3'(s)) begin ok = 1; break; end
    end
  endtask

  task automatic expect_step(input int c, input int ef, input int el);
    bit ok = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (upd_o[c]) begin ok = 1; break; end
    end
    chk("update seen", c, ok, 1);
    chk("step freq",   c, freq_o[c], ef);
    chk("step locked", c, lock_o[c], el);
    $display("step ch%0d freq=0x%05h locked=%0b t=%0t", c, freq_o[c], lock_o[c], $time);
  endtask

  task automatic measure_latency(input string nm, input int ef);
    bit ok;
    int cyc = 0;
    wait_state(0, 1, 5, ok);
    chk({nm, " settle entry"}, 0, ok, 1);
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      cyc++;
      if (upd_o[0]) break;
    end
    chk({nm, " latency"}, 0, cyc, 1009);
    chk({nm, " freq"},    0, freq_o[0], ef);
    chk({nm, " locked"},  0, lock_o[0], 0);
    $display("step ch0 freq=0x%05h after %0d cycles t=%0t", freq_o[0], cyc, $time);
  endtask

  int t3_val [6] = '{900, 800, 700, 600, 500, 650};
  int t3_f   [5] = '{'h9C80, 'h9CC0, 'h9C80, 'h9CC0, 'h9C80};
  int t3_l   [5] = '{0, 0, 0, 1, 1};

  initial begin
    bit ok;
    repeat (10) @(negedge clk);
    nrst = 1'b0;

    // Idle with enable low: nothing moves.
    repeat (1000) @(negedge clk);
    chk("idle freq",   0, freq_o[0], 'h9C40);
    chk("idle l",      0, l_o[0],    'h0FA);
    chk("idle state",  0, st_o[0],   0);
    chk("idle locked", 0, lock_o[0], 0);

    // Saturation at both ends of the range.
    fork
      begin
        en[1] = 1'b1;
        expect_step(1, 'hC000, 0);
        expect_step(1, 'hBFC0, 0);
        expect_step(1, 'hC000, 0);
        en[1] = 1'b0;
      end
      begin
        en[2] = 1'b1;
        expect_step(2, 'h8060, 0);
        expect_step(2, 'h8020, 0);
        expect_step(2, 'h8000, 0);
        expect_step(2, 'h8040, 0);
        en[2] = 1'b0;
      end
    join

    // First steps with flat amplitude.
    val0  = 12'd1000;
    en[0] = 1'b1;
    measure_latency("first", 'h9C80);
    expect_step(0, 'h9CC0, 0);

    // Falling averages force consecutive reversals until lock.
    for (int k = 0; k < 5; k++) begin
      val0 = 12'(t3_val[k]);
      expect_step(0, t3_f[k], t3_l[k]);
    end

    // Heartbeat drop after 3 of 8 samples.
    val0 = 12'(t3_val[5]);
    wait_state(0, 2, 1100, ok);
    chk("accum reached", 0, ok, 1);
    repeat (3) @(negedge clk);
    alive[0] = 1'b0;
    @(negedge clk);
    chk("abort state",  0, st_o[0],   0);
    chk("abort freq",   0, freq_o[0], 'h9C80);
    chk("abort locked", 0, lock_o[0], 0);
    repeat (3) @(negedge clk);
    alive[0] = 1'b1;
    measure_latency("restart", 'h9C40);
    val0 = 12'd700;
    expect_step(0, 'h9C00, 0);

    // Asynchronous reset in the middle of SETTLE, checked before any clock edge.
    repeat (5) @(negedge clk);
    #2 nrst = 1'b1;
    #1;
    chk("rst freq",        0, freq_o[0], 'h9C40);
    chk("rst state",       0, st_o[0],   0);
    chk("rst locked",      0, lock_o[0], 0);
    chk("rst freq_update", 0, upd_o[0],  0);
    chk("rst l",           0, l_o[0],    'h0FA);
    en[0] = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
